// File: rtl/gsim_pkg.sv
// Shared constants, state encoding and width helpers for the banded Gauss-Seidel solver.
package gsim_pkg;

    localparam int C1       = 13;
    localparam int C2       = 6;
    localparam int C3       = 1;
    localparam int DIAG     = 20;
    localparam int RECIP_SH = 18;
    localparam int RECIP    = (1 << RECIP_SH) / DIAG;
    localparam int REC_W    = $clog2(RECIP + 1);

    typedef enum logic [1:0] {LOAD, CALC, OUT} state_e;

    // Headroom for 13*(a+b) plus the other band terms without overflow.
    function automatic int acc_width(input int x_w);
        return x_w + 6;
    endfunction

endpackage

// File: rtl/gsim_update_dp.sv
// Three-stage single-unknown update: neighbour products, band sum, reciprocal scale and |delta|.
module gsim_update_dp
    import gsim_pkg::*;
#(
    parameter int X_W  = 32,
    parameter int B_W  = 16,
    parameter int FRAC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic signed [X_W-1:0] i_xm1,
    input  logic signed [X_W-1:0] i_xm2,
    input  logic signed [X_W-1:0] i_xm3,
    input  logic signed [X_W-1:0] i_xp1,
    input  logic signed [X_W-1:0] i_xp2,
    input  logic signed [X_W-1:0] i_xp3,
    input  logic signed [B_W-1:0] i_b,
    input  logic signed [X_W-1:0] i_x_old,
    output logic signed [X_W-1:0] o_xn,
    output logic        [X_W-1:0] o_absd
);
    localparam int ACC_W  = acc_width(X_W);
    localparam int PROD_W = ACC_W + REC_W;
    localparam logic signed [PROD_W-1:0] X_MAX = {{(PROD_W-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
    localparam logic signed [PROD_W-1:0] X_MIN = {{(PROD_W-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  w_s1, w_s2, w_s3, w_p1, w_p2, w_p3;
    logic signed [ACC_W-1:0]  r_p1, r_p2, r_p3, r_s;
    logic signed [PROD_W-1:0] w_prod, w_q;
    logic signed [X_W:0]      w_diff, w_mag;

    assign w_s1 = ACC_W'(i_xm1) + ACC_W'(i_xp1);
    assign w_s2 = ACC_W'(i_xm2) + ACC_W'(i_xp2);
    assign w_s3 = ACC_W'(i_xm3) + ACC_W'(i_xp3);

    // Constant-coefficient products as shift-add trees.
    always_comb begin
        w_p1 = ACC_W'(i_b) <<< FRAC;
        w_p2 = '0;
        w_p3 = '0;
        for (int k = 0; k < 8; k++) begin
            if (C3[k]) w_p1 = w_p1 + (w_s3 <<< k);
            if (C2[k]) w_p2 = w_p2 + (w_s2 <<< k);
            if (C1[k]) w_p3 = w_p3 + (w_s1 <<< k);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1 <= '0;
            r_p2 <= '0;
            r_p3 <= '0;
            r_s  <= '0;
        end else begin
            r_p1 <= w_p1;
            r_p2 <= w_p2;
            r_p3 <= w_p3;
            r_s  <= r_p1 - r_p2 + r_p3;
        end
    end

    always_comb begin
        w_prod = '0;
        for (int k = 0; k < REC_W; k++) begin
            if (RECIP[k]) w_prod = w_prod + (PROD_W'(r_s) <<< k);
        end
        w_q = w_prod >>> RECIP_SH;
        if (w_q > X_MAX)      o_xn = X_MAX[X_W-1:0];
        else if (w_q < X_MIN) o_xn = X_MIN[X_W-1:0];
        else                  o_xn = w_q[X_W-1:0];
        w_diff = (X_W+1)'(o_xn) - (X_W+1)'(i_x_old);
        w_mag  = w_diff[X_W] ? -w_diff : w_diff;
        o_absd = w_mag[X_W] ? '1 : w_mag[X_W-1:0];
    end

endmodule

// File: rtl/gsim_param.sv
// Parametrised Gauss-Seidel solver: b/x storage, load/sweep/output sequencing, convergence exit.
module gsim_param
    import gsim_pkg::*;
#(
    parameter int N    = 16,
    parameter int B_W  = 16,
    parameter int FRAC = 16,
    parameter int X_W  = 32,
    parameter int IT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_en,
    input  logic signed [B_W-1:0] b_in,
    output logic                  in_ready,
    input  logic [IT_W-1:0]       iter_max,
    input  logic [X_W-1:0]        tol,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [X_W-1:0] x_out,
    output logic                  out_last,
    output logic [IT_W-1:0]       iter_count,
    output logic                  converged
);
    localparam int IDX_W = $clog2(N);

    state_e                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [1:0]            r_phase;
    logic [IT_W-1:0]       r_sweep, r_iter_max, r_iter_count;
    logic [X_W-1:0]        r_tol, r_maxd;
    logic                  r_conv;
    logic signed [X_W-1:0] r_x [N];
    logic signed [B_W-1:0] r_b [N];

    logic signed [X_W-1:0] w_lo [3];
    logic signed [X_W-1:0] w_hi [3];
    logic signed [X_W-1:0] w_xn, w_x_cur;
    logic [X_W-1:0]        w_absd, w_maxd_new;
    logic [IT_W-1:0]       w_sweep_inc;
    logic                  w_last_idx, w_load_acc, w_wr_calc;

    // Out-of-range neighbours read as zero; lower ones already hold this sweep's values.
    always_comb begin
        for (int k = 1; k <= 3; k++) begin
            w_lo[k-1] = '0;
            w_hi[k-1] = '0;
            if (int'(r_idx) >= k)    w_lo[k-1] = r_x[IDX_W'(int'(r_idx) - k)];
            if (int'(r_idx) + k < N) w_hi[k-1] = r_x[IDX_W'(int'(r_idx) + k)];
        end
    end

    assign w_x_cur     = r_x[r_idx];
    assign w_last_idx  = (r_idx == IDX_W'(N - 1));
    assign w_load_acc  = (r_state == LOAD) && in_en;
    assign w_wr_calc   = (r_state == CALC) && (r_phase == 2'd2);
    assign w_maxd_new  = (w_absd > r_maxd) ? w_absd : r_maxd;
    assign w_sweep_inc = r_sweep + IT_W'(1);

    gsim_update_dp #(
        .X_W  (X_W),
        .B_W  (B_W),
        .FRAC (FRAC)
    ) u_dp (
        .clk     (clk),
        .reset   (reset),
        .i_xm1   (w_lo[0]),
        .i_xm2   (w_lo[1]),
        .i_xm3   (w_lo[2]),
        .i_xp1   (w_hi[0]),
        .i_xp2   (w_hi[1]),
        .i_xp3   (w_hi[2]),
        .i_b     (r_b[r_idx]),
        .i_x_old (w_x_cur),
        .o_xn    (w_xn),
        .o_absd  (w_absd)
    );

    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            r_b[r_idx] <= b_in;
            r_x[r_idx] <= X_W'(b_in) <<< FRAC;
        end else if (w_wr_calc) begin
            r_x[r_idx] <= w_xn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= LOAD;
            r_idx        <= '0;
            r_phase      <= '0;
            r_sweep      <= '0;
            r_iter_max   <= '0;
            r_tol        <= '0;
            r_maxd       <= '0;
            r_iter_count <= '0;
            r_conv       <= 1'b0;
        end else begin
            case (r_state)
                LOAD: if (in_en) begin
                    if (r_idx == '0) begin
                        r_iter_max   <= (iter_max == '0) ? IT_W'(1) : iter_max;
                        r_tol        <= tol;
                        r_iter_count <= '0;
                        r_conv       <= 1'b0;
                    end
                    if (w_last_idx) begin
                        r_idx   <= '0;
                        r_sweep <= '0;
                        r_phase <= '0;
                        r_maxd  <= '0;
                        r_state <= CALC;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                CALC: if (r_phase != 2'd2) begin
                    r_phase <= r_phase + 2'd1;
                end else begin
                    r_phase <= '0;
                    if (!w_last_idx) begin
                        r_idx  <= r_idx + IDX_W'(1);
                        r_maxd <= w_maxd_new;
                    end else begin
                        r_idx        <= '0;
                        r_maxd       <= '0;
                        r_iter_count <= w_sweep_inc;
                        if (w_maxd_new <= r_tol) begin
                            r_conv  <= 1'b1;
                            r_state <= OUT;
                        end else if (w_sweep_inc == r_iter_max) begin
                            r_conv  <= 1'b0;
                            r_state <= OUT;
                        end else begin
                            r_sweep <= w_sweep_inc;
                        end
                    end
                end
                OUT: if (out_ready) begin
                    if (w_last_idx) begin
                        r_idx   <= '0;
                        r_state <= LOAD;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    assign in_ready   = (r_state == LOAD);
    assign out_valid  = (r_state == OUT);
    assign out_last   = out_valid && w_last_idx;
    assign x_out      = out_valid ? w_x_cur : '0;
    assign iter_count = r_iter_count;
    assign converged  = r_conv;

endmodule

// File: tb/tb_gsim_param.sv
// Bench for gsim_param: three instances (N=16/4/64) against a plain-arithmetic Gauss-Seidel model.
module tb_gsim_param;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        en_v, rdy_v, inr_v, val_v, last_v, conv_v;
    logic signed [15:0] b_in;
    logic [7:0]        iter_max;
    logic [31:0]       tol;
    logic [31:0]       x_v [3];
    logic [7:0]        itc_v [3];

    int     tests = 0;
    int     fails = 0;
    int     sel = 0;
    int     beat = 0;
    bit     chk_on = 1'b0;
    int     n_of [3] = '{16, 4, 64};
    int     mb [64];
    longint exp_x [64];
    longint exp_it;
    longint exp_conv;

    always #5 clk = ~clk;

    gsim_param #(.N(16)) u_n16 (
        .clk(clk), .reset(reset), .in_en(en_v[0]), .b_in(b_in), .in_ready(inr_v[0]),
        .iter_max(iter_max), .tol(tol), .out_valid(val_v[0]), .out_ready(rdy_v[0]),
        .x_out(x_v[0]), .out_last(last_v[0]), .iter_count(itc_v[0]), .converged(conv_v[0])
    );
    gsim_param #(.N(4)) u_n4 (
        .clk(clk), .reset(reset), .in_en(en_v[1]), .b_in(b_in), .in_ready(inr_v[1]),
        .iter_max(iter_max), .tol(tol), .out_valid(val_v[1]), .out_ready(rdy_v[1]),
        .x_out(x_v[1]), .out_last(last_v[1]), .iter_count(itc_v[1]), .converged(conv_v[1])
    );
    gsim_param #(.N(64)) u_n64 (
        .clk(clk), .reset(reset), .in_en(en_v[2]), .b_in(b_in), .in_ready(inr_v[2]),
        .iter_max(iter_max), .tol(tol), .out_valid(val_v[2]), .out_ready(rdy_v[2]),
        .x_out(x_v[2]), .out_last(last_v[2]), .iter_count(itc_v[2]), .converged(conv_v[2])
    );

    task automatic check(input string name, input longint got, input longint expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Plain Gauss-Seidel over the banded Toeplitz matrix, in Q16 with floor((s*13107)/2^18).
    task automatic model_run(input int n, input int itmax, input longint tl);
        longint x [70];
        longint s, xn, d, md;
        int lim;
        lim = (itmax == 0) ? 1 : itmax;
        for (int i = 0; i < 70; i++) x[i] = 0;
        for (int i = 0; i < n; i++) x[i+3] = longint'(mb[i]) * 65536;
        exp_conv = 0;
        exp_it   = 0;
        for (int sw = 0; sw < lim; sw++) begin
            md = 0;
            for (int i = 0; i < n; i++) begin
                s = longint'(mb[i]) * 65536 + 13 * (x[i+2] + x[i+4])
                    - 6 * (x[i+1] + x[i+5]) + (x[i] + x[i+6]);
                xn = (s * 13107) >>> 18;
                if (xn > 64'sd2147483647) xn = 64'sd2147483647;
                if (xn < -64'sd2147483648) xn = -64'sd2147483648;
                d = xn - x[i+3];
                if (d < 0) d = -d;
                if (d > md) md = d;
                x[i+3] = xn;
            end
            exp_it = sw + 1;
            if (md <= tl) begin
                exp_conv = 1;
                break;
            end
        end
        for (int i = 0; i < n; i++) exp_x[i] = x[i+3];
    endtask

    function automatic longint xe(input int j, input int n);
        return (j < 0 || j >= n) ? 0 : exp_x[j];
    endfunction

    always @(negedge clk) begin
        if (chk_on && !reset && val_v[sel]) begin
            if (beat >= n_of[sel]) begin
                check("extra_beat", beat, n_of[sel] - 1);
            end else begin
                check("x_out", longint'($signed(x_v[sel])), exp_x[beat]);
                check("out_last", longint'(last_v[sel]), longint'(beat == n_of[sel] - 1));
                check("iter_count", longint'(itc_v[sel]), exp_it);
                check("converged", longint'(conv_v[sel]), exp_conv);
            end
            if (rdy_v[sel]) beat++;
        end
    end

    task automatic load_vec(input int s, input int itmax, input longint tl);
        iter_max = 8'(itmax);
        tol      = 32'(tl);
        for (int i = 0; i < n_of[s]; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                check("clear_iter_on_load", longint'(itc_v[s]), 0);
                check("clear_conv_on_load", longint'(conv_v[s]), 0);
                iter_max = 8'd3;
                tol      = '0;
            end
            if (i == 5) begin
                en_v = '0;
                @(posedge clk); #1;
            end
            en_v = 3'(1 << s);
            b_in = 16'(mb[i]);
        end
        @(posedge clk); #1;
        en_v = '0;
    endtask

    task automatic drain(input int s, input bit bp);
        int cyc = 0;
        while (beat < n_of[s] && cyc < 30000) begin
            @(posedge clk); #1;
            cyc++;
            if (!bp || (cyc % 4 == 1) || (cyc % 4 == 0)) rdy_v = 3'(1 << s);
            else rdy_v = '0;
        end
        check("beats", beat, n_of[s]);
        rdy_v  = '0;
        chk_on = 1'b0;
        check("back_in_load", longint'(inr_v[s]), 1);
        check("hold_iter", longint'(itc_v[s]), exp_it);
        check("hold_conv", longint'(conv_v[s]), exp_conv);
    endtask

    task automatic run_case(input int s, input int itmax, input longint tl, input bit bp);
        sel = s;
        model_run(n_of[s], itmax, tl);
        beat   = 0;
        chk_on = 1'b1;
        load_vec(s, itmax, tl);
        drain(s, bp);
    endtask

    initial begin
        int     cyc;
        int     bad;
        longint r, rmax;
        en_v = '0; rdy_v = '0; b_in = '0; iter_max = '0; tol = '0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_in_ready", longint'(inr_v[0]), 1);
        check("rst_out_valid", longint'(val_v[0]), 0);
        check("rst_out_last", longint'(last_v[0]), 0);
        check("rst_iter_count", longint'(itc_v[0]), 0);
        check("rst_converged", longint'(conv_v[0]), 0);
        check("rst_x_out", longint'(x_v[0]), 0);
        @(posedge clk); #1 reset = 1'b0;

        // Zeros: converges on first sweep.
        for (int i = 0; i < 64; i++) mb[i] = 0;
        run_case(0, 10, 0, 1'b0);
        check("pin_zero_it", exp_it, 1);
        check("pin_zero_conv", exp_conv, 1);

        // Iteration cap of one sweep.
        for (int i = 0; i < 16; i++) mb[i] = i * 100;
        run_case(0, 1, 0, 1'b0);
        check("pin_cap_it", exp_it, 1);
        check("pin_cap_conv", exp_conv, 0);
        check("pin_cap_x0", exp_x[0], 1310700);

        // Alternating b: converges well before the cap.
        for (int i = 0; i < 16; i++) mb[i] = (i % 2 == 0) ? 1000 : -1000;
        run_case(0, 255, 16, 1'b0);
        check("pin_conv_flag", exp_conv, 1);
        check("pin_conv_under_cap", longint'(exp_it < 255), 1);
        rmax = 0;
        for (int i = 0; i < 16; i++) begin
            r = 20 * xe(i, 16) - 13 * (xe(i-1, 16) + xe(i+1, 16)) + 6 * (xe(i-2, 16) + xe(i+2, 16))
                - (xe(i-3, 16) + xe(i+3, 16)) - longint'(mb[i]) * 65536;
            if (r < 0) r = -r;
            if (r > rmax) rmax = r;
        end
        check("residual_small", longint'(rmax < 4096), 1);

        // Same case under 1,0,0,1 backpressure.
        run_case(0, 255, 16, 1'b1);

        // Reset during CALC.
        sel = 0;
        chk_on = 1'b0;
        load_vec(0, 255, 16);
        cyc = 0;
        while (inr_v[0] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("calc_entered", longint'(inr_v[0]), 0);
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_in_ready", longint'(inr_v[0]), 1);
        check("midrst_out_valid", longint'(val_v[0]), 0);
        @(posedge clk); #1 reset = 1'b0;
        rdy_v = 3'b001;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (val_v[0]) bad++;
        end
        rdy_v = '0;
        check("no_partial_output", bad, 0);
        run_case(0, 255, 16, 1'b0);

        // iter_max=0 acts as one sweep, at both ends of the N range.
        for (int i = 0; i < 64; i++) mb[i] = 0;
        mb[0] = 20;
        run_case(1, 0, 0, 1'b0);
        check("pin_n4_x0", exp_x[0], 65535);
        check("pin_n4_x1", exp_x[1], 42597);
        check("pin_n4_x2", exp_x[2], 8027);
        check("pin_n4_it", exp_it, 1);
        run_case(2, 0, 0, 1'b0);
        check("pin_n64_x0", exp_x[0], 65535);
        check("pin_n64_it", exp_it, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
